// File: rtl/sum_reader.sv
// ============================================================================
//  Module   : sum_reader
//  Purpose  : Reads the four group sums (RAM words 7, 15, 23, 31) after the
//             summing controller signals ready_in, and hands each one
//             downstream with a valid/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_reader #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2   // RAM read latency in cycles, legal 1..4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_in,
  input  logic [DATA_W-1:0] q,
  output logic [4:0]        address,
  output logic              rden,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ack,
  output logic [1:0]        grp,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  // Value of the latency counter on the last rden-high cycle.
  localparam logic [2:0] LAT_LAST = RD_LAT[2:0];

  logic [2:0]        state, state_next;
  logic [1:0]        idx, idx_d;
  logic [2:0]        lat_cnt, lat_d;
  logic [4:0]        address_d;
  logic              rden_d;
  logic [DATA_W-1:0] dout_d;
  logic              valid_d;
  logic [1:0]        grp_d;
  logic              busy_d;
  logic              done_d;
  logic              overrun_d;

  logic              lat_last;
  logic              xfer;
  logic [1:0]        idx_inc;

  assign lat_last = (lat_cnt == LAT_LAST);
  assign xfer     = dout_valid & dout_ack;   // ack without valid is ignored
  assign idx_inc  = idx + 2'd1;

  // State register and registered outputs; reset abandons any readout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      lat_cnt    <= 3'd0;
      address    <= 5'd0;
      rden       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      grp        <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_d;
      lat_cnt    <= lat_d;
      address    <= address_d;
      rden       <= rden_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      grp        <= grp_d;
      busy       <= busy_d;
      done       <= done_d;
      overrun    <= overrun_d;
    end
  end

  // Next-state logic for the readout sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:          if (ready_in) state_next = S_READ;
      S_READ, S_WAIT:  state_next = lat_last ? S_PRESENT : S_WAIT;
      S_PRESENT:       if (xfer) state_next = (idx == 2'd3) ? S_FINISH : S_NEXT;
      S_NEXT:          state_next = S_READ;
      S_FINISH:        state_next = S_IDLE;
      default:         state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    idx_d     = idx;
    lat_d     = lat_cnt;
    address_d = address;
    rden_d    = rden;
    dout_d    = dout;
    valid_d   = dout_valid;
    grp_d     = grp;
    busy_d    = busy;
    done_d    = 1'b0;
    // busy is still high during FINISH, so a ready_in coinciding with done
    // is flagged here and never starts a new readout.
    overrun_d = overrun | (ready_in & busy);
    case (state)
      S_IDLE: begin
        if (ready_in) begin
          idx_d     = 2'd0;
          address_d = 5'b00111;
          rden_d    = 1'b1;
          busy_d    = 1'b1;
          lat_d     = 3'd1;
        end
      end
      S_READ, S_WAIT: begin
        if (lat_last) begin
          dout_d  = q;
          valid_d = 1'b1;
          rden_d  = 1'b0;
          grp_d   = idx;
        end else begin
          lat_d = lat_cnt + 3'd1;
        end
      end
      S_PRESENT: begin
        if (xfer) begin
          valid_d = 1'b0;
          done_d  = (idx == 2'd3);
        end
      end
      S_NEXT: begin
        idx_d     = idx_inc;
        address_d = {idx_inc, 3'b111};
        rden_d    = 1'b1;
        lat_d     = 3'd1;
      end
      S_FINISH: begin
        busy_d    = 1'b0;
        address_d = 5'd0;
        idx_d     = 2'd0;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
